// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory between instruction-fetch and data ports; all outputs registered.
// gnt at N+1, rdy at N+MEM_LAT+1; requesters hold req until rdy, one access in flight at a time.
module mem_arb #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_gnt,
   output logic        if_rdy,
   output logic [31:0] if_data,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rdy,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       ptr_dm;
   logic       win_dm;
   logic       gnt_if_nxt, gnt_dm_nxt;
   logic       last_beat;

   assign last_beat = (cnt == 4'(MEM_LAT - 1));

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      gnt_if_nxt = 1'b0;
      gnt_dm_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (dm_req && (ptr_dm || !if_req)) gnt_dm_nxt = 1'b1;
            else if (if_req)                   gnt_if_nxt = 1'b1;
            if (dm_req || if_req) state_nxt = ACCESS;
         end
         ACCESS:  if (last_beat) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         cnt       <= '0;
         ptr_dm    <= 1'b1;
         win_dm    <= 1'b0;
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rdy    <= 1'b0;
         dm_rdy    <= 1'b0;
         if_data   <= '0;
         dm_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_gnt <= gnt_if_nxt;
         dm_gnt <= gnt_dm_nxt;
         if_rdy <= 1'b0;
         dm_rdy <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (gnt_if_nxt || gnt_dm_nxt) begin
                  win_dm   <= gnt_dm_nxt;
                  mem_en   <= 1'b1;
                  mem_we   <= gnt_dm_nxt & dm_we;
                  mem_addr <= gnt_dm_nxt ? dm_addr : if_addr;
                  if (gnt_dm_nxt) mem_wdata <= dm_wdata;
                  // pointer only moves when both ports competed
                  if (if_req && dm_req) ptr_dm <= ~ptr_dm;
               end
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (last_beat) begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if_rdy <= ~win_dm;
                  dm_rdy <= win_dm;
                  if (!mem_we) begin
                     if (win_dm) dm_rdata <= mem_rdata;
                     else        if_data  <= mem_rdata;
                  end
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: main instance at MEM_LAT=2, plus MEM_LAT=1 and 15 instances for latency.
module tb_mem_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_f;
   logic        if_req, dm_req, dm_we;
   logic [15:0] if_addr, dm_addr;
   logic [31:0] dm_wdata, mem_rdata;
   logic        if_gnt, if_rdy, dm_gnt, dm_rdy, mem_en, mem_we;
   logic [31:0] if_data, dm_rdata, mem_wdata;
   logic [15:0] mem_addr;

   logic        a_if_req, a_if_gnt, a_if_rdy, a_dm_gnt, a_dm_rdy, a_mem_en, a_mem_we;
   logic [31:0] a_if_data, a_dm_rdata, a_mem_wdata;
   logic [15:0] a_mem_addr;
   logic        b_if_req, b_if_gnt, b_if_rdy, b_dm_gnt, b_dm_rdy, b_mem_en, b_mem_we;
   logic [31:0] b_if_data, b_dm_rdata, b_mem_wdata;
   logic [15:0] b_mem_addr;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arb #(.MEM_LAT(2)) dut (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdy(if_rdy), .if_data(if_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rdy(dm_rdy), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_arb #(.MEM_LAT(1)) dut_lat1 (
      .clk(clk), .rst_f(rst_f),
      .if_req(a_if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rdy(a_if_rdy), .if_data(a_if_data),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
      .dm_gnt(a_dm_gnt), .dm_rdy(a_dm_rdy), .dm_rdata(a_dm_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(32'hCAFE_0001)
   );

   mem_arb #(.MEM_LAT(15)) dut_lat15 (
      .clk(clk), .rst_f(rst_f),
      .if_req(b_if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rdy(b_if_rdy), .if_data(b_if_data),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
      .dm_gnt(b_dm_gnt), .dm_rdy(b_dm_rdy), .dm_rdata(b_dm_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(32'hCAFE_000F)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1 of the IDLE cycle in which the winner's request is high.
   // mode 1: change dm_addr during ACCESS; mode 2: drop the request during ACCESS.
   task automatic txn(input bit dm, input bit we, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rd, input logic [31:0] exp_data, input int mode);
      mem_rdata = rd;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         chk("gnt",       32'(dm ? dm_gnt : if_gnt), 32'(k == 1));
         chk("gnt_other", 32'(dm ? if_gnt : dm_gnt), 32'd0);
         chk("mem_en",    32'(mem_en), 32'(k == 1 || k == 2));
         chk("mem_we",    32'(mem_we), 32'((k == 1 || k == 2) && we));
         chk("rdy",       32'(dm ? dm_rdy : if_rdy), 32'(k == 3));
         chk("rdy_other", 32'(dm ? if_rdy : dm_rdy), 32'd0);
         if (k >= 1) chk("mem_addr", 32'(mem_addr), 32'(addr));
         if (k >= 1 && we) chk("mem_wdata", mem_wdata, wdata);
         if (k == 3) chk("rdata", dm ? dm_rdata : if_data, exp_data);
         @(posedge clk); #1;
         if (k == 0 && mode == 1) dm_addr = 16'h0001;
         if ((k == 0 && mode == 2) || k == 3) begin
            if (dm) dm_req = 1'b0;
            else    if_req = 1'b0;
         end
      end
   endtask

   initial begin
      int a_g, a_r, b_g, b_r;
      rst_f = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      a_if_req = 1'b0; b_if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_gnt",    32'({if_gnt, dm_gnt, if_rdy, dm_rdy}), 32'd0);
      chk("rst_data",   if_data | dm_rdata, 32'd0);
      chk("rst_mem",    32'(mem_addr) | mem_wdata, 32'd0);
      rst_f = 1'b1;
      @(posedge clk); #1;

      // single fetch
      if_addr = 16'h0010; if_req = 1'b1;
      txn(0, 0, 16'h0010, 32'h0, 32'h8000_1234, 32'h8000_1234, 0);

      // first contested pair: data wins, fetch served in the following IDLE
      dm_addr = 16'h0020; dm_we = 1'b0; if_addr = 16'h0030;
      dm_req = 1'b1; if_req = 1'b1;
      txn(1, 0, 16'h0020, 32'h0, 32'h1111_2222, 32'h1111_2222, 0);
      txn(0, 0, 16'h0030, 32'h0, 32'h3333_4444, 32'h3333_4444, 0);

      // second contested pair: fetch wins
      if_addr = 16'h0040; dm_addr = 16'h0050;
      dm_req = 1'b1; if_req = 1'b1;
      txn(0, 0, 16'h0040, 32'h0, 32'h5555_6666, 32'h5555_6666, 0);
      txn(1, 0, 16'h0050, 32'h0, 32'h7777_8888, 32'h7777_8888, 0);

      // store leaves dm_rdata untouched
      dm_we = 1'b1; dm_addr = 16'h00FF; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
      txn(1, 1, 16'h00FF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h7777_8888, 0);
      @(negedge clk);
      chk("idle_mem_we",    32'(mem_we), 32'd0);
      chk("idle_mem_addr",  32'(mem_addr), 32'h0000_00FF);
      chk("idle_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // address change during ACCESS is ignored
      dm_we = 1'b0; dm_addr = 16'h0002; dm_req = 1'b1;
      txn(1, 0, 16'h0002, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1);

      // request dropped during ACCESS still completes
      if_addr = 16'h0077; if_req = 1'b1;
      txn(0, 0, 16'h0077, 32'h0, 32'h2468_2468, 32'h2468_2468, 2);

      // reset in the middle of an access
      dm_addr = 16'h0100; dm_req = 1'b1; mem_rdata = 32'hAAAA_5555;
      @(posedge clk); #2;
      chk("pre_rst_gnt", 32'(dm_gnt), 32'd1);
      rst_f = 1'b0;
      #1;
      chk("arst_en_gnt", 32'({mem_en, mem_we, dm_gnt, if_gnt}), 32'd0);
      chk("arst_mem",    32'(mem_addr) | mem_wdata, 32'd0);
      chk("arst_data",   if_data | dm_rdata, 32'd0);
      dm_req = 1'b0;
      @(posedge clk); #1;
      rst_f = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_rdy",   32'({dm_rdy, if_rdy, mem_en}), 32'd0);
         chk("post_rst_rdata", dm_rdata, 32'd0);
      end
      @(posedge clk); #1;
      if_addr = 16'h0099; if_req = 1'b1;
      txn(0, 0, 16'h0099, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF, 0);

      // latency extremes
      a_g = 0; a_r = 0; b_g = 0; b_r = 0;
      if_addr = 16'h0123; a_if_req = 1'b1; b_if_req = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (a_if_gnt && a_g == 0) a_g = c;
         if (b_if_gnt && b_g == 0) b_g = c;
         if (a_if_rdy && a_r == 0) begin a_r = c; a_if_req = 1'b0; end
         if (b_if_rdy && b_r == 0) begin b_r = c; b_if_req = 1'b0; end
      end
      chk("lat1_gnt_cycle",  32'(a_g), 32'd1);
      chk("lat1_rdy_cycle",  32'(a_r), 32'd2);
      chk("lat1_data",       a_if_data, 32'hCAFE_0001);
      chk("lat15_gnt_cycle", 32'(b_g), 32'd1);
      chk("lat15_rdy_cycle", 32'(b_r), 32'd16);
      chk("lat15_data",      b_if_data, 32'hCAFE_000F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (mem_en to valid mem_rdata); legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_f  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_rdy.
REQ-005 SHALL have port if_addr  input  16  fetch word address.
REQ-006 SHALL have port if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 SHALL have port if_rdy  output  1  one-cycle pulse: if_data valid.
REQ-008 SHALL have port if_data  output  32  fetched instruction word.
REQ-009 SHALL have port dm_req  input  1  data (LOD/STR) request, held until dm_rdy.
REQ-010 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_addr  input  16  data word address.
REQ-012 SHALL have port dm_wdata  input  32  store data.
REQ-013 SHALL have port dm_gnt  output  1  one-cycle pulse: data request accepted.
REQ-014 SHALL have port dm_rdy  output  1  one-cycle pulse: access complete, dm_rdata valid for loads.
REQ-015 SHALL have port dm_rdata  output  32  load data.
REQ-016 SHALL have port mem_en  output  1  memory access enable.
REQ-017 SHALL have port mem_we  output  1  memory write enable.
REQ-018 SHALL have port mem_addr  output  16  memory address.
REQ-019 SHALL have port mem_wdata  output  32  memory write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-021 SHALL implement FSM with states IDLE, ACCESS, DONE; all outputs registered.
REQ-022 IDLE: no request -> stay IDLE; any request sampled high -> ACCESS at next edge.
REQ-023 Single requester high in IDLE SHALL be granted regardless of priority pointer.
REQ-024 Both requests high in IDLE SHALL grant per priority pointer; pointer then points to the other requester (round-robin); pointer updates only on a grant.
REQ-025 On entry to ACCESS, SHALL latch winner identity, address, we (fetch: we=0) and wdata; later changes on requester inputs SHALL be ignored until DONE.
REQ-026 gnt of winner SHALL be high exactly in the first ACCESS cycle.
REQ-027 mem_en SHALL be high for exactly MEM_LAT cycles (all of ACCESS); mem_addr/mem_wdata/mem_we SHALL be stable throughout; mem_we = latched we.
REQ-028 4-bit counter SHALL count ACCESS cycles; after MEM_LAT-th ACCESS cycle -> DONE.
REQ-029 At ACCESS->DONE edge, read transaction SHALL capture mem_rdata into winner's data register; stores SHALL leave dm_rdata unchanged.
REQ-030 DONE SHALL last one cycle with winner's rdy high; DONE -> IDLE unconditionally.
REQ-031 if_data/dm_rdata SHALL hold value until that port's next read completion.
REQ-032 Latency: req first high in IDLE cycle N -> gnt at N+1, rdy at N+MEM_LAT+1; min request-to-request spacing MEM_LAT+2 cycles.
REQ-033 Requester SHALL drop req in cycle after rdy; req still high in IDLE is a new request.
REQ-034 Request dropped during ACCESS SHALL not abort the transaction; rdy still pulses.
REQ-035 Only one of if_gnt/dm_gnt, one of if_rdy/dm_rdy SHALL be high in any cycle.
REQ-036 When not in ACCESS, mem_en = mem_we = 0; mem_addr/mem_wdata hold last value.

Reset
REQ-037 rst_f low SHALL immediately force IDLE, counter 0, pointer = data port, all gnt/rdy/mem_en/mem_we = 0, mem_addr/mem_wdata/if_data/dm_rdata = 0.
REQ-038 Reset during ACCESS SHALL abort the access with no rdy and no data capture; memory write may be partially applied.
REQ-039 First request after rst_f rises SHALL be sampled no earlier than first rising edge with rst_f high.

Verification
REQ-040 Fetch only, MEM_LAT=2, if_addr=0x0010, mem returns 0x8000_1234 -> if_gnt at N+1, mem_en 2 cycles, if_rdy at N+3, if_data=0x8000_1234.
REQ-041 if_req and dm_req both high after reset -> data granted first, fetch granted in next IDLE; second simultaneous pair -> fetch first.
REQ-042 Store dm_addr=0x00FF, dm_wdata=0xDEAD_BEEF -> mem_we=1 and mem_wdata=0xDEAD_BEEF for 2 cycles, dm_rdy pulses, dm_rdata unchanged.
REQ-043 Change dm_addr to 0x0001 during ACCESS of load at 0x0002 -> mem_addr stays 0x0002.
REQ-044 rst_f low mid-ACCESS -> all outputs 0 same cycle, no rdy; next request after release completes normally.
REQ-045 MEM_LAT=1 and MEM_LAT=15 -> rdy at N+2 and N+16 respectively.
